// File: rtl/alu_mext.sv
// alu_mext: RV32 execute unit with single-cycle base ALU ops and an optional iterative M-extension.
// Define ALU_MEXT_EN to build the multiply/divide datapath; otherwise M ops complete flagged illegal.
module alu_mext #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic [2:0]      func3,
  input  logic [6:0]      func7,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out,
  output logic            illegal
);

`ifdef ALU_MEXT_EN
  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, DONE} state_t;
`endif

  state_t          state_q, state_d;
  logic [XLEN-1:0] out_q, out_d;
  logic            illegal_q, illegal_d;
  logic            inXfer, mOp, alt;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] baseRes, sraRes;

  assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign out_valid = (state_q == DONE);
  assign out       = out_q;
  assign illegal   = illegal_q;
  assign inXfer    = in_valid & in_ready;
  assign mOp       = (func7 == 7'h01);
  assign alt       = (func7 == 7'h20);
  assign shamt     = op2[SHW-1:0];
  assign sraRes    = $signed(op1) >>> shamt;

  always_comb begin
    baseRes = '0;
    case (func3)
      3'b000:  baseRes = alt ? (op1 - op2) : (op1 + op2);
      3'b001:  baseRes = op1 << shamt;
      3'b010:  baseRes = {{(XLEN-1){1'b0}}, ($signed(op1) < $signed(op2))};
      3'b011:  baseRes = {{(XLEN-1){1'b0}}, (op1 < op2)};
      3'b100:  baseRes = op1 ^ op2;
      3'b101:  baseRes = alt ? sraRes : (op1 >> shamt);
      3'b110:  baseRes = op1 | op2;
      default: baseRes = op1 & op2;
    endcase
  end

`ifdef ALU_MEXT_EN
  // hi/lo hold the running product, or remainder/quotient while dividing
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d, opb_q, opb_d;
  logic [SHW:0]      cnt_q, cnt_d;
  logic [2:0]        fn_q, fn_d;
  logic              neg_q, neg_d;
  logic              isDiv, sgn1, sgn2, neg1, neg2, divZero, divOvf;
  logic [XLEN-1:0]   mag1, mag2, shortRes, quoFix, remFix, mRes;
  logic [XLEN:0]     mulSum, divShift, divDiff;
  logic [2*XLEN-1:0] prodFix;

  assign isDiv   = func3[2];
  assign sgn1    = (func3 == 3'b001) | (func3 == 3'b010) | (func3 == 3'b100) | (func3 == 3'b110);
  assign sgn2    = (func3 == 3'b001) | (func3 == 3'b100) | (func3 == 3'b110);
  assign neg1    = sgn1 & op1[XLEN-1];
  assign neg2    = sgn2 & op2[XLEN-1];
  assign mag1    = neg1 ? -op1 : op1;
  assign mag2    = neg2 ? -op2 : op2;
  assign divZero = isDiv & (op2 == '0);
  assign divOvf  = isDiv & ~func3[0] & (op1 == {1'b1, {(XLEN-1){1'b0}}}) & (&op2);

  always_comb begin
    shortRes = '0;
    if (divZero) shortRes = func3[1] ? op1 : '1;
    else         shortRes = func3[1] ? '0 : op1;
  end

  assign mulSum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
  assign divShift = {hi_q, lo_q[XLEN-1]};
  assign divDiff  = divShift - {1'b0, opb_q};
  assign prodFix  = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
  assign quoFix   = neg_q ? -lo_q : lo_q;
  assign remFix   = neg_q ? -hi_q : hi_q;

  always_comb begin
    mRes = remFix;
    case (fn_q)
      3'b000:                 mRes = prodFix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: mRes = prodFix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         mRes = quoFix;
      default:                mRes = remFix;
    endcase
  end
`endif

  always_comb begin
    state_d   = state_q;
    out_d     = out_q;
    illegal_d = illegal_q;
`ifdef ALU_MEXT_EN
    hi_d  = hi_q;
    lo_d  = lo_q;
    opb_d = opb_q;
    cnt_d = cnt_q;
    fn_d  = fn_q;
    neg_d = neg_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (inXfer) begin
          if (!mOp) begin
            state_d   = DONE;
            out_d     = baseRes;
            illegal_d = 1'b0;
          end else begin
`ifdef ALU_MEXT_EN
            if (divZero | divOvf) begin
              state_d   = DONE;
              out_d     = shortRes;
              illegal_d = 1'b0;
            end else begin
              // multiplication is commutative, so both op classes load the same way
              state_d = BUSY;
              hi_d    = '0;
              lo_d    = mag1;
              opb_d   = mag2;
              cnt_d   = (SHW+1)'(XLEN);
              fn_d    = func3;
              neg_d   = (isDiv & func3[1]) ? neg1 : (neg1 ^ neg2);
            end
`else
            state_d   = DONE;
            out_d     = '0;
            illegal_d = 1'b1;
`endif
          end
        end else if ((state_q == DONE) && out_ready) begin
          state_d = IDLE;
        end
      end
`ifdef ALU_MEXT_EN
      BUSY: begin
        if (fn_q[2]) begin
          hi_d = divDiff[XLEN] ? divShift[XLEN-1:0] : divDiff[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], ~divDiff[XLEN]};
        end else begin
          {hi_d, lo_d} = {mulSum, lo_q[XLEN-1:1]};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == (SHW+1)'(1)) state_d = FIX;
      end
      FIX: begin
        state_d   = DONE;
        out_d     = mRes;
        illegal_d = 1'b0;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      out_q     <= '0;
      illegal_q <= 1'b0;
`ifdef ALU_MEXT_EN
      hi_q  <= '0;
      lo_q  <= '0;
      opb_q <= '0;
      cnt_q <= '0;
      fn_q  <= '0;
      neg_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      illegal_q <= illegal_d;
`ifdef ALU_MEXT_EN
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      opb_q <= opb_d;
      cnt_q <= cnt_d;
      fn_q  <= fn_d;
      neg_q <= neg_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_mext.sv
// tb_alu_mext: scoreboard bench for alu_mext; M-ext expectations follow the ALU_MEXT_EN define.
`timescale 1ns/1ps
module tb_alu_mext;
  localparam int XLEN = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic [2:0]  func3 = '0;
  logic [6:0]  func7 = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out;
  logic        illegal;

  int          vecCount = 0;
  int          missCount = 0;
  longint      cyc = 0;
  logic [32:0] expQ[$];
  logic [32:0] monExp;

  alu_mext #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op1(op1), .op2(op2), .func3(func3), .func7(func7),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .illegal(illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Scoreboard: every output transfer must match the oldest expected {illegal, out}
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      vecCount++;
      if (expQ.size() == 0) begin
        missCount++;
        $display("[TB] FAIL scoreboard_extra got out=%h illegal=%b, none expected", out, illegal);
      end else begin
        monExp = expQ.pop_front();
        if ({illegal, out} !== monExp) begin
          missCount++;
          $display("[TB] FAIL scoreboard got out=%h illegal=%b exp out=%h illegal=%b",
                   out, illegal, monExp[31:0], monExp[32]);
        end
      end
    end
  end

  function automatic logic [31:0] refBase(input logic [2:0] f3, input logic [6:0] f7,
                                          input logic [31:0] a, input logic [31:0] b);
    logic               altOp;
    int                 sh;
    logic signed [31:0] sa;
    altOp = (f7 == 7'h20);
    sh    = int'(b[4:0]);
    sa    = a;
    case (f3)
      3'd0: return altOp ? a - b : a + b;
      3'd1: return a << sh;
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: begin
        if (altOp) return sa >>> sh;
        return a >> sh;
      end
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  // Presents an op, waits (bounded) for acceptance, and records its expected result
  task automatic sendOp(input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] expOut, input logic expIll);
    int n = 0;
    in_valid = 1'b1;
    func3 = f3; func7 = f7; op1 = a; op2 = b;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    vecCount++;
    if (!in_ready) begin
      missCount++;
      $display("[TB] FAIL accept_timeout got in_ready=%b exp 1", in_ready);
    end else begin
      expQ.push_back({expIll, expOut});
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic waitOut(output int n);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    vecCount += 4;
    if (out_valid !== 1'b0) begin missCount++; $display("[TB] FAIL reset_out_valid got %b exp 0", out_valid); end
    if (in_ready !== 1'b1) begin missCount++; $display("[TB] FAIL reset_in_ready got %b exp 1", in_ready); end
    if (out !== 32'h0) begin missCount++; $display("[TB] FAIL reset_out got %h exp 0", out); end
    if (illegal !== 1'b0) begin missCount++; $display("[TB] FAIL reset_illegal got %b exp 0", illegal); end
    @(posedge clk); #1;
  endtask

  task automatic test_base_ops;
    logic [2:0]  f3s[11] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7, 3'd0};
    logic [6:0]  f7s[11] = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00, 7'h20, 7'h00, 7'h20, 7'h00, 7'h00, 7'h15};
    logic [31:0] exps[11] = '{32'h0000_0014, 32'hFFFF_FFCC, 32'hFFFF_FF00, 32'h1, 32'h0,
                              32'hFFFF_FFD4, 32'h0FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF4,
                              32'h0000_0020, 32'h0000_0014};
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      sendOp(f3s[i], f7s[i], 32'hFFFF_FFF0, 32'h0000_0024, exps[i], 1'b0);
      waitOut(lat);
      vecCount++;
      if (lat !== 0) begin missCount++; $display("[TB] FAIL base_latency[%0d] got %0d exp 0", i, lat); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back;
    longint      startCyc;
    logic [31:0] a, b;
    logic [6:0]  f7;
    logic [2:0]  f3;
    int          n;
    out_ready = 1'b1;
    startCyc = cyc;
    for (int i = 0; i < 24; i++) begin
      a = $urandom; b = $urandom; f3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 2))
        0: f7 = 7'h00;
        1: f7 = 7'h20;
        default: f7 = 7'h15;
      endcase
      if (i < 8) begin a = 32'hFFFF_FFF0; b = 32'h0000_0024; f3 = 3'(i); f7 = 7'h00; end
      sendOp(f3, f7, a, b, refBase(f3, f7, a, b), 1'b0);
    end
    vecCount++;
    if (cyc - startCyc != 24) begin
      missCount++;
      $display("[TB] FAIL b2b_throughput got %0d cycles exp 24", cyc - startCyc);
    end
    n = 0;
    while (expQ.size() != 0 && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
  endtask

  task automatic test_mext;
    int lat;
    bit busyReady;
    logic [2:0]  f3s[7] = '{3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd0, 3'd3};
    logic [31:0] as[7]  = '{32'h8000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'd7, 32'hFFFF_FFFF};
    logic [31:0] bs[7]  = '{32'h8000_0000, 32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
`ifdef ALU_MEXT_EN
    logic [31:0] exps[7] = '{32'hC000_0000, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                             32'hFFFF_FFEB, 32'hFFFF_FFFE};
    out_ready = 1'b1;
    sendOp(3'd1, 7'h01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0);
    lat = 0; busyReady = 0;
    @(negedge clk);
    while (!out_valid && lat < 100) begin
      if (in_ready) busyReady = 1;
      @(negedge clk);
      lat++;
    end
    vecCount += 2;
    if (lat !== 33) begin missCount++; $display("[TB] FAIL mulh_latency got %0d exp 33", lat); end
    if (busyReady !== 1'b0) begin missCount++; $display("[TB] FAIL busy_in_ready got %b exp 0", busyReady); end
    @(posedge clk); #1;
    for (int i = 0; i < 7; i++) begin
      sendOp(f3s[i], 7'h01, as[i], bs[i], exps[i], 1'b0);
      waitOut(lat);
      vecCount++;
      if (lat !== 33) begin missCount++; $display("[TB] FAIL mext_latency[%0d] got %0d exp 33", i, lat); end
      @(posedge clk); #1;
    end
`else
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      sendOp(f3s[i], 7'h01, as[i], bs[i], 32'h0, 1'b1);
      waitOut(lat);
      vecCount++;
      if (lat !== 0) begin missCount++; $display("[TB] FAIL illegal_latency[%0d] got %0d exp 0", i, lat); end
      @(posedge clk); #1;
    end
    busyReady = 0;
    vecCount++;
    if (busyReady !== 1'b0) begin missCount++; $display("[TB] FAIL busy_in_ready got %b exp 0", busyReady); end
`endif
  endtask

  task automatic test_short_circuit;
    int lat;
    logic [2:0]  f3s[6] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6};
    logic [31:0] as[6]  = '{32'h0000_1234, 32'h0000_1234, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs[6]  = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
`ifdef ALU_MEXT_EN
    logic [31:0] exps[6] = '{32'hFFFF_FFFF, 32'h0000_1234, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'h8000_0000, 32'h0};
    logic        expIll = 1'b0;
`else
    logic [31:0] exps[6] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    logic        expIll = 1'b1;
`endif
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      sendOp(f3s[i], 7'h01, as[i], bs[i], exps[i], expIll);
      waitOut(lat);
      vecCount++;
      if (lat !== 0) begin missCount++; $display("[TB] FAIL short_latency[%0d] got %0d exp 0", i, lat); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stall;
    int lat;
    out_ready = 1'b0;
    sendOp(3'd4, 7'h00, 32'h1234_5678, 32'h0F0F_0F0F, 32'h1D3B_5977, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vecCount += 3;
      if (out_valid !== 1'b1) begin missCount++; $display("[TB] FAIL stall_valid[%0d] got %b exp 1", i, out_valid); end
      if (out !== 32'h1D3B_5977) begin missCount++; $display("[TB] FAIL stall_out[%0d] got %h exp 1d3b5977", i, out); end
      if (in_ready !== 1'b0) begin missCount++; $display("[TB] FAIL stall_in_ready[%0d] got %b exp 0", i, in_ready); end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    sendOp(3'd6, 7'h00, 32'h1234_5678, 32'h0F0F_0F0F, 32'h1F3F_5F7F, 1'b0);
    waitOut(lat);
    vecCount += 2;
    if (lat !== 0) begin missCount++; $display("[TB] FAIL stall_release_latency got %0d exp 0", lat); end
    if (out !== 32'h1F3F_5F7F) begin missCount++; $display("[TB] FAIL stall_release_out got %h exp 1f3f5f7f", out); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    sendOp(3'd6, 7'h00, 32'hA5A5_0000, 32'h0000_5A5A, 32'hA5A5_5A5A, 1'b0);
`ifdef ALU_MEXT_EN
    out_ready = 1'b1;
    sendOp(3'd5, 7'h01, 32'd1000, 32'd3, 32'd333, 1'b0);
`endif
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    expQ.delete();
    @(negedge clk);
    vecCount += 4;
    if (out_valid !== 1'b0) begin missCount++; $display("[TB] FAIL midreset_valid got %b exp 0", out_valid); end
    if (out !== 32'h0) begin missCount++; $display("[TB] FAIL midreset_out got %h exp 0", out); end
    if (in_ready !== 1'b1) begin missCount++; $display("[TB] FAIL midreset_in_ready got %b exp 1", in_ready); end
    if (illegal !== 1'b0) begin missCount++; $display("[TB] FAIL midreset_illegal got %b exp 0", illegal); end
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    test_reset();
    test_base_ops();
    test_back_to_back();
    test_mext();
    test_short_circuit();
    test_stall();
    test_reset_mid();
    sendOp(3'd7, 7'h00, 32'hFFFF_0000, 32'h00FF_FF00, 32'h00FF_0000, 1'b0);
    n = 0;
    while (expQ.size() != 0 && n < 100) begin @(negedge clk); n++; end
    vecCount++;
    if (expQ.size() != 0) begin
      missCount++;
      $display("[TB] FAIL drain got %0d pending exp 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
